// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a stable lock with a
// bounded number of timed attempts, and holds downstream logic in reset until locked.
module pll_lock_supervisor #(
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic       lost_lock,
   output logic [3:0] retry_count
);

   localparam int unsigned HOLD_W = $clog2(PLL_RST_CYCLES + 1);
   localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);

   localparam logic [2:0] ST_HOLD   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_STABLE = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_FAULT  = 3'd4;

   logic              sync1_q, sync2_q, locked_s;
   logic [2:0]        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
   logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
   logic [3:0]        retry_q, retry_d;
   logic              pll_rst_q, pll_rst_d, sys_rst_q, sys_rst_d;
   logic              ready_q, ready_d, fault_q, fault_d, lost_q, lost_d;
   logic              hold_done, tmo_hit, stab_hit, timeout;

   assign locked_s = sync2_q;

   // State, counters, synchroniser and registered outputs
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         stab_cnt_q <= '0;
         retry_q    <= 4'd0;
         pll_rst_q  <= 1'b1;
         sys_rst_q  <= 1'b1;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         sync1_q    <= pll_locked;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         stab_cnt_q <= stab_cnt_d;
         retry_q    <= retry_d;
         pll_rst_q  <= pll_rst_d;
         sys_rst_q  <= sys_rst_d;
         ready_q    <= ready_d;
         fault_q    <= fault_d;
         lost_q     <= lost_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      stab_cnt_d = stab_cnt_q;
      retry_d    = retry_q;
      lost_d     = 1'b0;
      timeout    = 1'b0;

      hold_done = (32'(hold_cnt_q) + 32'd1) >= PLL_RST_CYCLES;
      tmo_hit   = (32'(tmo_cnt_q) + 32'd1) >= LOCK_TIMEOUT_CYCLES;
      stab_hit  = (32'(stab_cnt_q) + 32'd1) >= LOCK_STABLE_CYCLES;
      // Timeout counter saturates: a lock seen on the final cycle can still carry it past the limit
      tmo_inc   = (32'(tmo_cnt_q) >= LOCK_TIMEOUT_CYCLES) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);

      case (state_q)
         ST_HOLD: begin
            if (hold_done) begin
               state_d    = ST_WAIT;
               hold_cnt_d = '0;
               tmo_cnt_d  = '0;
               stab_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_WAIT: begin
            tmo_cnt_d = tmo_inc;
            if (locked_s) begin
               stab_cnt_d = STAB_W'(1);
               state_d    = (LOCK_STABLE_CYCLES <= 32'd1) ? ST_RUN : ST_STABLE;
            end else if (tmo_hit) begin
               timeout = 1'b1;
            end
         end
         ST_STABLE: begin
            tmo_cnt_d = tmo_inc;
            if (locked_s) begin
               // Completion beats a coincident timeout
               if (stab_hit) begin
                  state_d = ST_RUN;
               end else begin
                  stab_cnt_d = stab_cnt_q + STAB_W'(1);
                  timeout    = tmo_hit;
               end
            end else begin
               stab_cnt_d = '0;
               state_d    = ST_WAIT;
               timeout    = tmo_hit;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               lost_d     = 1'b1;
               retry_d    = 4'd0;
               hold_cnt_d = '0;
               state_d    = ST_HOLD;
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_HOLD;
      endcase

      if (timeout) begin
         hold_cnt_d = '0;
         stab_cnt_d = '0;
         if (retry_q == 4'(MAX_RETRIES)) begin
            state_d = ST_FAULT;
         end else begin
            retry_d = retry_q + 4'd1;
            state_d = ST_HOLD;
         end
      end

      pll_rst_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
      sys_rst_d = (state_d != ST_RUN);
      ready_d   = (state_d == ST_RUN);
      fault_d   = (state_d == ST_FAULT);
   end

   assign pll_rst     = pll_rst_q;
   assign sys_rst     = sys_rst_q;
   assign ready       = ready_q;
   assign fault       = fault_q;
   assign lost_lock   = lost_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock behaviour,
// every cycle compared against an event-level model of the supervisor's rules.
module tb_pll_lock_supervisor;

   localparam int unsigned P_RST  = 4;
   localparam int unsigned P_TMO  = 32;
   localparam int unsigned P_STAB = 8;
   localparam int unsigned P_MAX  = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst, ready, fault, lost_lock;
   logic [3:0] retry_count;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: remaining reset-pulse cycles, cycles since waiting began, lock run length
   int m_hold_left, m_elapsed, m_run_len, m_retries;
   bit m_running, m_fault, m_lost, m_sy0, m_sy1;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES(P_RST), .LOCK_TIMEOUT_CYCLES(P_TMO),
      .LOCK_STABLE_CYCLES(P_STAB), .MAX_RETRIES(P_MAX)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
      .sys_rst(sys_rst), .ready(ready), .fault(fault), .lost_lock(lost_lock),
      .retry_count(retry_count)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_step(input bit r, input bit pl);
      bit ls;
      int prev;
      ls = m_sy1;
      if (r) begin
         m_hold_left = P_RST; m_elapsed = 0; m_run_len = 0; m_retries = 0;
         m_running = 0; m_fault = 0; m_lost = 0; m_sy0 = 0; m_sy1 = 0;
         return;
      end
      m_lost = 0;
      if (m_fault) begin
      end else if (m_running) begin
         if (!ls) begin
            m_lost = 1; m_running = 0; m_retries = 0; m_hold_left = P_RST;
         end
      end else if (m_hold_left > 0) begin
         m_hold_left--;
         if (m_hold_left == 0) begin
            m_elapsed = 0; m_run_len = 0;
         end
      end else begin
         prev = m_run_len;
         m_elapsed++;
         m_run_len = ls ? m_run_len + 1 : 0;
         if (m_run_len >= int'(P_STAB)) m_running = 1;
         else if (m_elapsed >= int'(P_TMO) && !(prev == 0 && ls)) begin
            if (m_retries == int'(P_MAX)) m_fault = 1;
            else begin
               m_retries++; m_hold_left = P_RST;
            end
         end
      end
      m_sy1 = m_sy0;
      m_sy0 = pl;
   endtask

   task automatic tick();
      bit r, pl;
      r  = rst;
      pl = pll_locked;
      @(posedge refclk);
      model_step(r, pl);
      #1;
      check("pll_rst", 32'(pll_rst), 32'(m_fault || (!m_running && m_hold_left > 0)));
      check("sys_rst", 32'(sys_rst), 32'(!m_running));
      check("ready", 32'(ready), 32'(m_running));
      check("fault", 32'(fault), 32'(m_fault));
      check("lost_lock", 32'(lost_lock), 32'(m_lost));
      check("retry_count", 32'(retry_count), 32'(m_retries));
   endtask

   task automatic measure_pll_rst(output int cnt);
      cnt = 0;
      while (pll_rst && cnt < 20) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      int n, cnt, k;
      bit level;
      int len;

      // 1: reset pulse length after release
      rst = 1'b1; pll_locked = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      measure_pll_rst(cnt);
      check("t1_pll_rst_len", 32'(cnt), 32'd4);
      check("t1_ready", 32'(ready), 32'd0);

      // 2: lock arrives 5 cycles into waiting, release latency
      repeat (5) tick();
      pll_locked = 1'b1;
      n = 0;
      do begin
         tick(); n++;
      end while (!ready && n < 40);
      check("t2_lock_latency", 32'(n), 32'd10);
      check("t2_sys_rst", 32'(sys_rst), 32'd0);
      repeat (3) tick();

      // 4: single-cycle lock drop in RUN
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      n = 0;
      do begin
         tick(); n++;
      end while (!lost_lock && n < 10);
      check("t4_lost_delay", 32'(n), 32'd2);
      check("t4_sys_rst", 32'(sys_rst), 32'd1);
      check("t4_retry", 32'(retry_count), 32'd0);
      measure_pll_rst(cnt);
      check("t4_pll_rst_len", 32'(cnt), 32'd4);
      n = 0;
      while (!ready && n < 60) begin
         tick(); n++;
      end
      check("t4_relock", 32'(ready), 32'd1);

      // 3: lock never arrives -> fault after three attempts
      rst = 1'b1; pll_locked = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      n = 0;
      while (!fault && n < 400) begin
         tick(); n++;
      end
      check("t3_fault", 32'(fault), 32'd1);
      check("t3_fault_cycles", 32'(n), 32'(3 * (P_RST + P_TMO)));
      check("t3_retry", 32'(retry_count), 32'd2);
      repeat (6) tick();
      check("t3_pll_rst_held", 32'(pll_rst), 32'd1);
      rst = 1'b1;
      tick();
      check("t3_fault_clr", 32'(fault), 32'd0);
      check("t3_retry_clr", 32'(retry_count), 32'd0);
      rst = 1'b0;

      // 5: flapping lock times out 32 cycles after waiting begins
      measure_pll_rst(cnt);
      k = 0; n = 0;
      while (retry_count == 4'd0 && n < 100) begin
         pll_locked = (k % 6) < 5;
         k++;
         tick(); n++;
      end
      check("t5_timeout_cycles", 32'(n), 32'd32);
      check("t5_retry", 32'(retry_count), 32'd1);

      // 6: reset during the stability window
      rst = 1'b1; pll_locked = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (!(m_run_len == 6 && !m_running) && n < 40) begin
         tick(); n++;
      end
      rst = 1'b1;
      tick();
      check("t6_pll_rst", 32'(pll_rst), 32'd1);
      check("t6_sys_rst", 32'(sys_rst), 32'd1);
      check("t6_ready", 32'(ready), 32'd0);
      check("t6_lost", 32'(lost_lock), 32'd0);
      rst = 1'b0;
      measure_pll_rst(cnt);
      check("t6_pll_rst_len", 32'(cnt), 32'd4);

      // Random lock behaviour with rare glitches and resets
      n = 0;
      while (n < 3000) begin
         level = ($urandom_range(0, 9) < 7);
         len   = int'($urandom_range(1, 30));
         for (int i = 0; i < len; i++) begin
            pll_locked = level ^ ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 399) == 0);
            tick(); n++;
         end
      end
      rst = 1'b0;
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
